// File: rtl/bus_arb_rr.sv
// bus_arb_rr: N-master round-robin OCP arbiter with in-order ID FIFO for response routing.
// Optional BUS_ARB_PRIO0_EN makes master 0 a fixed-priority port.
module bus_arb_rr #(
  parameter int N_MASTERS       = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int BE             = DATA_WIDTH / 8,
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [N_MASTERS*3-1:0]           m_cmd,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_addr,
  input  logic [N_MASTERS*DATA_WIDTH-1:0]  m_data,
  input  logic [N_MASTERS*BE-1:0]          m_byteen,
  output logic [N_MASTERS-1:0]             m_cmd_accept,
  output logic [N_MASTERS*2-1:0]           m_resp,
  output logic [N_MASTERS*DATA_WIDTH-1:0]  m_resp_data,
  output logic [2:0]                       s_cmd,
  output logic [ADDR_WIDTH-1:0]            s_addr,
  output logic [DATA_WIDTH-1:0]            s_data,
  output logic [BE-1:0]                    s_byteen,
  input  logic                             s_cmd_accept,
  input  logic [1:0]                       s_resp,
  input  logic [DATA_WIDTH-1:0]            s_resp_data,
  output logic [CW-1:0]                    outstanding,
  output logic                             err_orphan
);
  localparam int IW = $clog2(N_MASTERS);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
`ifdef BUS_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic [N_MASTERS-1:0] req;
  logic [IW-1:0]        g, rr_ptr_q, rr_ptr_d, held_q, held_d;
  logic                 hold_q, hold_d, found, full, push, pop;
  logic                 err_orphan_q, err_orphan_d;
  logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]        count_q, count_d;
  logic [IW-1:0]        fifo_q [MAX_OUTSTANDING];
  logic [IW-1:0]        fifo_d [MAX_OUTSTANDING];

  always_comb begin
    for (int i = 0; i < N_MASTERS; i++)
      req[i] = (m_cmd[i*3 +: 3] == 3'd1) || (m_cmd[i*3 +: 3] == 3'd2);
  end

  // A held grant wins outright; otherwise search cyclically from rr_ptr (skipping 0 in priority mode).
  always_comb begin
    g     = held_q;
    found = hold_q;
    if (PRIO && !hold_q && req[0]) begin
      g     = '0;
      found = 1'b1;
    end
    for (int k = 0; k < N_MASTERS; k++)
      if (!found && req[(int'(rr_ptr_q) + k) % N_MASTERS] &&
          !(PRIO && ((int'(rr_ptr_q) + k) % N_MASTERS) == 0)) begin
        g     = IW'((int'(rr_ptr_q) + k) % N_MASTERS);
        found = 1'b1;
      end
  end

  always_comb begin
    full     = count_q == CW'(MAX_OUTSTANDING);
    s_cmd    = (reset_n && !full && found && req[g]) ? m_cmd[g*3 +: 3] : 3'd0;
    s_addr   = m_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    s_data   = m_data[g*DATA_WIDTH +: DATA_WIDTH];
    s_byteen = m_byteen[g*BE +: BE];
    push     = s_cmd_accept && (s_cmd != 3'd0);
    pop      = (s_resp != 2'd0) && (count_q != '0);
    m_cmd_accept    = '0;
    m_cmd_accept[g] = push;
    m_resp          = '0;
    if (pop)
      m_resp[fifo_q[rd_q]*2 +: 2] = s_resp;
    m_resp_data = {N_MASTERS{s_resp_data}};
    outstanding = count_q;
    err_orphan  = err_orphan_q;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push && !(PRIO && g == '0))
      rr_ptr_d = (g == IW'(N_MASTERS - 1)) ? IW'(PRIO) : g + IW'(1);
    hold_d = (s_cmd != 3'd0) && !s_cmd_accept;
    held_d = g;
    fifo_d = fifo_q;
    if (push)
      fifo_d[wr_q] = g;
    wr_d = push ? ((wr_q == PW'(MAX_OUTSTANDING - 1)) ? PW'(0) : wr_q + PW'(1)) : wr_q;
    rd_d = pop ? ((rd_q == PW'(MAX_OUTSTANDING - 1)) ? PW'(0) : rd_q + PW'(1)) : rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
    err_orphan_d = err_orphan_q || ((s_resp != 2'd0) && (count_q == '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q     <= '0;
      held_q       <= '0;
      hold_q       <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
      count_q      <= '0;
      err_orphan_q <= 1'b0;
      fifo_q       <= '{default: '0};
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      held_q       <= held_d;
      hold_q       <= hold_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      count_q      <= count_d;
      err_orphan_q <= err_orphan_d;
      fifo_q       <= fifo_d;
    end
  end
endmodule

// File: tb/tb_bus_arb_rr.sv
// tb_bus_arb_rr: directed scenario tests for bus_arb_rr (N=4, MAX_OUTSTANDING=4).
// The priority-port scenario is compiled in only when BUS_ARB_PRIO0_EN is defined.
module tb_bus_arb_rr;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] m_cmd;
  logic [127:0] m_addr, m_data;
  logic [15:0] m_byteen;
  logic [3:0]  m_cmd_accept;
  logic [7:0]  m_resp;
  logic [127:0] m_resp_data;
  logic [2:0]  s_cmd;
  logic [31:0] s_addr, s_data;
  logic [3:0]  s_byteen;
  logic        s_cmd_accept;
  logic [1:0]  s_resp;
  logic [31:0] s_resp_data;
  logic [2:0]  outstanding;
  logic        err_orphan;
  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  bus_arb_rr #(.N_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset_n(reset_n), .m_cmd(m_cmd), .m_addr(m_addr), .m_data(m_data),
    .m_byteen(m_byteen), .m_cmd_accept(m_cmd_accept), .m_resp(m_resp),
    .m_resp_data(m_resp_data), .s_cmd(s_cmd), .s_addr(s_addr), .s_data(s_data),
    .s_byteen(s_byteen), .s_cmd_accept(s_cmd_accept), .s_resp(s_resp),
    .s_resp_data(s_resp_data), .outstanding(outstanding), .err_orphan(err_orphan)
  );

  task automatic set_m(input int i, input logic [2:0] c);
    m_cmd[i*3 +: 3] = c;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    m_cmd = '0;
    s_cmd_accept = 1'b0;
    s_resp = 2'd0;
    s_resp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    #3;
    checks++; if (s_cmd !== 3'd0) begin fails++; $display("FAIL reset_s_cmd: got %0d want 0", s_cmd); end
    checks++; if (m_cmd_accept !== 4'h0) begin fails++; $display("FAIL reset_accept: got %b want 0000", m_cmd_accept); end
    checks++; if (m_resp !== 8'h00) begin fails++; $display("FAIL reset_m_resp: got %h want 00", m_resp); end
    checks++; if (outstanding !== 3'd0) begin fails++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    checks++; if (err_orphan !== 1'b0) begin fails++; $display("FAIL reset_err_orphan: got %b want 0", err_orphan); end
    step();
  endtask

  task automatic test_round_robin;
    int prev;
    do_reset();
    for (int i = 0; i < 4; i++) set_m(i, 3'd2);
    s_cmd_accept = 1'b1;
    for (int c = 0; c < 8; c++) begin
      prev = (c + 3) % 4;
      s_resp = (c > 0) ? 2'd1 : 2'd0;
      s_resp_data = 32'h1000 + prev;
      #4;
      checks++; if (s_addr !== 32'h100 * (c % 4)) begin fails++; $display("FAIL rr_grant c%0d: s_addr=%h want %h", c, s_addr, 32'h100 * (c % 4)); end
      checks++; if (m_cmd_accept !== 4'b1 << (c % 4)) begin fails++; $display("FAIL rr_accept c%0d: got %b want %b", c, m_cmd_accept, 4'b1 << (c % 4)); end
      checks++; if (outstanding !== ((c > 0) ? 3'd1 : 3'd0)) begin fails++; $display("FAIL rr_outstanding c%0d: got %0d", c, outstanding); end
      if (c > 0) begin
        checks++; if (m_resp !== 8'b01 << (2 * prev)) begin fails++; $display("FAIL rr_resp c%0d: got %h want %h", c, m_resp, 8'b01 << (2 * prev)); end
        checks++; if (m_resp_data[prev*32 +: 32] !== 32'h1000 + prev) begin fails++; $display("FAIL rr_resp_data c%0d: got %h want %h", c, m_resp_data[prev*32 +: 32], 32'h1000 + prev); end
      end
      step();
    end
    m_cmd = '0;
    s_resp = 2'd1;
    s_resp_data = 32'h1003;
    #4;
    checks++; if (m_resp !== 8'h40) begin fails++; $display("FAIL rr_drain_resp: got %h want 40", m_resp); end
    step();
    s_resp = 2'd0;
    #4;
    checks++; if (outstanding !== 3'd0) begin fails++; $display("FAIL rr_drain_outstanding: got %0d want 0", outstanding); end
    step();
  endtask

  task automatic test_hold;
    do_reset();
    set_m(1, 3'd2);
    s_cmd_accept = 1'b1;
    #4;
    checks++; if (m_cmd_accept !== 4'b0010) begin fails++; $display("FAIL hold_pre_accept: got %b want 0010", m_cmd_accept); end
    step();
    set_m(1, 3'd0); set_m(0, 3'd2); set_m(2, 3'd1); set_m(3, 3'd2);
    s_resp_data = 32'h1001;
    for (int c = 0; c < 4; c++) begin
      s_cmd_accept = (c == 3);
      s_resp = (c == 0) ? 2'd1 : 2'd0;
      #4;
      checks++; if (s_cmd !== 3'd1 || s_data !== 32'hDEADBEEF || s_addr !== 32'h200 || s_byteen !== 4'h4) begin
        fails++; $display("FAIL hold_cmd c%0d: s_cmd=%0d s_data=%h s_addr=%h s_byteen=%h want 1/deadbeef/200/4", c, s_cmd, s_data, s_addr, s_byteen);
      end
      checks++; if (m_cmd_accept !== ((c == 3) ? 4'b0100 : 4'b0000)) begin fails++; $display("FAIL hold_accept c%0d: got %b", c, m_cmd_accept); end
      if (c == 0) begin
        checks++; if (m_resp !== 8'h04) begin fails++; $display("FAIL hold_resp_m1: got %h want 04", m_resp); end
      end
      step();
    end
    set_m(2, 3'd0);
    s_cmd_accept = 1'b0;
    s_resp = 2'd0;
    #4;
    checks++; if (s_addr !== 32'h300) begin fails++; $display("FAIL hold_next_grant: s_addr=%h want 300", s_addr); end
    checks++; if (outstanding !== 3'd1) begin fails++; $display("FAIL hold_outstanding: got %0d want 1", outstanding); end
    step();
  endtask

  task automatic test_full_and_reset_mid;
    do_reset();
    set_m(0, 3'd2);
    s_cmd_accept = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #4;
      checks++; if (s_cmd !== 3'd2 || outstanding !== 3'(c)) begin fails++; $display("FAIL full_fill c%0d: s_cmd=%0d outstanding=%0d", c, s_cmd, outstanding); end
      step();
    end
    #4;
    checks++; if (s_cmd !== 3'd0 || outstanding !== 3'd4 || m_cmd_accept !== 4'h0) begin
      fails++; $display("FAIL full_stall: s_cmd=%0d outstanding=%0d accept=%b want 0/4/0000", s_cmd, outstanding, m_cmd_accept);
    end
    step();
    s_resp = 2'd1;
    s_resp_data = 32'h1000;
    #4;
    checks++; if (s_cmd !== 3'd0) begin fails++; $display("FAIL full_same_cycle_pop: s_cmd=%0d want 0", s_cmd); end
    checks++; if (m_resp !== 8'h01) begin fails++; $display("FAIL full_pop_resp: got %h want 01", m_resp); end
    step();
    s_resp = 2'd0;
    #4;
    checks++; if (s_cmd !== 3'd2 || outstanding !== 3'd3 || m_cmd_accept !== 4'b0001) begin
      fails++; $display("FAIL full_refill: s_cmd=%0d outstanding=%0d accept=%b want 2/3/0001", s_cmd, outstanding, m_cmd_accept);
    end
    step();
    set_m(0, 3'd0);
    s_resp = 2'd1;
    step();
    s_resp = 2'd0;
    #4;
    checks++; if (outstanding !== 3'd3) begin fails++; $display("FAIL mid_pre_reset: outstanding=%0d want 3", outstanding); end
    reset_n = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin fails++; $display("FAIL mid_async_clear: outstanding=%0d want 0", outstanding); end
    set_m(1, 3'd2); set_m(3, 3'd2);
    s_cmd_accept = 1'b0;
    #1;
    checks++; if (s_cmd !== 3'd0 || m_cmd_accept !== 4'h0) begin fails++; $display("FAIL mid_in_reset: s_cmd=%0d accept=%b want 0/0000", s_cmd, m_cmd_accept); end
    step();
    reset_n = 1'b1;
    #3;
    checks++; if (s_cmd !== 3'd2 || s_addr !== 32'h100) begin fails++; $display("FAIL mid_lowest_grant: s_cmd=%0d s_addr=%h want 2/100", s_cmd, s_addr); end
    step();
    m_cmd = '0;
    s_resp = 2'd1;
    #4;
    checks++; if (m_resp !== 8'h00) begin fails++; $display("FAIL mid_discarded_resp: m_resp=%h want 00", m_resp); end
    step();
    s_resp = 2'd0;
    #4;
    checks++; if (err_orphan !== 1'b1) begin fails++; $display("FAIL mid_orphan: err_orphan=%b want 1", err_orphan); end
    step();
  endtask

  task automatic test_orphan;
    do_reset();
    s_resp = 2'd1;
    s_resp_data = 32'h55;
    #4;
    checks++; if (m_resp !== 8'h00 || err_orphan !== 1'b0) begin fails++; $display("FAIL orphan_pulse: m_resp=%h err_orphan=%b want 00/0", m_resp, err_orphan); end
    step();
    s_resp = 2'd0;
    for (int c = 0; c < 3; c++) begin
      #4;
      checks++; if (err_orphan !== 1'b1 || m_resp !== 8'h00) begin fails++; $display("FAIL orphan_sticky c%0d: err_orphan=%b m_resp=%h want 1/00", c, err_orphan, m_resp); end
      step();
    end
  endtask

`ifdef BUS_ARB_PRIO0_EN
  task automatic test_prio0;
    logic [3:0] exp;
    do_reset();
    set_m(0, 3'd2); set_m(1, 3'd2);
    s_cmd_accept = 1'b1;
    for (int c = 0; c < 6; c++) begin
      set_m(0, (c == 3) ? 3'd0 : 3'd2);
      s_resp = (c > 0) ? 2'd1 : 2'd0;
      exp = (c == 3) ? 4'b0010 : 4'b0001;
      #4;
      checks++; if (m_cmd_accept !== exp) begin fails++; $display("FAIL prio0_grant c%0d: got %b want %b", c, m_cmd_accept, exp); end
      step();
    end
  endtask
`endif

  initial begin
    m_addr   = {32'h300, 32'h200, 32'h100, 32'h000};
    m_data   = {32'hA3, 32'hDEADBEEF, 32'hA1, 32'hA0};
    m_byteen = 16'h8421;
    test_reset();
    test_round_robin();
    test_hold();
    test_full_and_reset_mid();
    test_orphan();
`ifdef BUS_ARB_PRIO0_EN
    test_prio0();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
